// File: rtl/wb_dest_pipe_if.sv
// Forwarding-producer bundle: decoded ID-stage fields in, staged Rs/Rt/Rd/RegWr
// plus hazard controls out.
interface wb_dest_pipe_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
);
  logic          id_valid;
  logic          id_regwr;
  logic          id_memtoreg;
  logic          id_uses_rt;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          flush;

  logic [RW-1:0] ID_Ex_Rs;
  logic [RW-1:0] ID_Ex_Rt;
  logic          Ex_Mem_RegWr;
  logic [RW-1:0] Ex_Mem_Rd;
  logic          Mem_Wr_RegWr;
  logic [RW-1:0] Mem_Wr_Rd;
  logic          pc_write;
  logic          if_id_write;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_regwr, id_memtoreg, id_uses_rt, id_rs, id_rt, id_rd, flush,
    input  ID_Ex_Rs, ID_Ex_Rt, Ex_Mem_RegWr, Ex_Mem_Rd, Mem_Wr_RegWr, Mem_Wr_Rd,
           pc_write, if_id_write, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_regwr, id_memtoreg, id_uses_rt, id_rs, id_rt, id_rd, flush,
    output ID_Ex_Rs, ID_Ex_Rt, Ex_Mem_RegWr, Ex_Mem_Rd, Mem_Wr_RegWr, Mem_Wr_Rd,
           pc_write, if_id_write, stall, stall_cnt
  );
endinterface

// File: rtl/wb_dest_pipe.sv
// Carries destination/RegWr through ID/EX, EX/MEM and MEM/WR for operand forwarding,
// and inserts a one-cycle bubble on load-use hazards, counting stall cycles.
module wb_dest_pipe #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_dest_pipe_if.slave    bus
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          r_ie_regwr;
  logic          r_ie_memtoreg;
  logic [RW-1:0] r_ie_rd;
  logic [RW-1:0] r_id_ex_rs;
  logic [RW-1:0] r_id_ex_rt;
  logic          r_ex_mem_regwr;
  logic [RW-1:0] r_ex_mem_rd;
  logic          r_mem_wr_regwr;
  logic [RW-1:0] r_mem_wr_rd;
  logic [CW-1:0] r_stall_cnt;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  // A load in EX whose destination is a live source of ID cannot be forwarded in time.
  always_comb begin
    w_hazard = bus.id_valid & r_ie_regwr & r_ie_memtoreg & (r_ie_rd != '0) &
               ((r_ie_rd == bus.id_rs) | (bus.id_uses_rt & (r_ie_rd == bus.id_rt)));
    w_stall  = w_hazard & ~bus.flush;
    w_bubble = w_stall | bus.flush;
  end

  // ID/EX stage: bubble on stall or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie_regwr    <= 1'b0;
      r_ie_memtoreg <= 1'b0;
      r_ie_rd       <= '0;
      r_id_ex_rs    <= '0;
      r_id_ex_rt    <= '0;
    end else if (w_bubble) begin
      r_ie_regwr    <= 1'b0;
      r_ie_memtoreg <= 1'b0;
      r_ie_rd       <= '0;
      r_id_ex_rs    <= '0;
      r_id_ex_rt    <= '0;
    end else begin
      r_ie_regwr    <= bus.id_regwr & bus.id_valid;
      r_ie_memtoreg <= bus.id_memtoreg & bus.id_valid;
      r_ie_rd       <= bus.id_rd;
      r_id_ex_rs    <= bus.id_rs;
      r_id_ex_rt    <= bus.id_rt;
    end
  end

  // EX/MEM and MEM/WR never stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_mem_regwr <= 1'b0;
      r_ex_mem_rd    <= '0;
      r_mem_wr_regwr <= 1'b0;
      r_mem_wr_rd    <= '0;
    end else begin
      r_ex_mem_regwr <= r_ie_regwr;
      r_ex_mem_rd    <= r_ie_rd;
      r_mem_wr_regwr <= r_ex_mem_regwr;
      r_mem_wr_rd    <= r_ex_mem_rd;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign bus.ID_Ex_Rs     = r_id_ex_rs;
  assign bus.ID_Ex_Rt     = r_id_ex_rt;
  assign bus.Ex_Mem_RegWr = r_ex_mem_regwr;
  assign bus.Ex_Mem_Rd    = r_ex_mem_rd;
  assign bus.Mem_Wr_RegWr = r_mem_wr_regwr;
  assign bus.Mem_Wr_Rd    = r_mem_wr_rd;
  assign bus.stall        = w_stall;
  assign bus.pc_write     = ~w_stall;
  assign bus.if_id_write  = ~w_stall;
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_wb_dest_pipe;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  wb_dest_pipe_if #(.RW(5), .CW(16)) bus ();
  wb_dest_pipe_if #(.RW(5), .CW(2))  bus2 ();

  wb_dest_pipe #(.RW(5), .CW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  wb_dest_pipe #(.RW(5), .CW(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.id_valid    = bus.id_valid;
  assign bus2.id_regwr    = bus.id_regwr;
  assign bus2.id_memtoreg = bus.id_memtoreg;
  assign bus2.id_uses_rt  = bus.id_uses_rt;
  assign bus2.id_rs       = bus.id_rs;
  assign bus2.id_rt       = bus.id_rt;
  assign bus2.id_rd       = bus.id_rd;
  assign bus2.flush       = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic ut,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic fl);
    bus.id_valid    = v;
    bus.id_regwr    = rw;
    bus.id_memtoreg = mr;
    bus.id_uses_rt  = ut;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.flush       = fl;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rs"},    32'(bus.ID_Ex_Rs), 32'd0);
    chk({tag, "_rt"},    32'(bus.ID_Ex_Rt), 32'd0);
    chk({tag, "_emrw"},  32'(bus.Ex_Mem_RegWr), 32'd0);
    chk({tag, "_emrd"},  32'(bus.Ex_Mem_Rd), 32'd0);
    chk({tag, "_mwrw"},  32'(bus.Mem_Wr_RegWr), 32'd0);
    chk({tag, "_mwrd"},  32'(bus.Mem_Wr_Rd), 32'd0);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_pcw"},   32'(bus.pc_write), 32'd1);
    chk({tag, "_ifw"},   32'(bus.if_id_write), 32'd1);
    chk({tag, "_cnt"},   32'(bus.stall_cnt), 32'd0);
    chk({tag, "_cnt2"},  32'(bus2.stall_cnt), 32'd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Load r8 then dependent add on Rs
    drive(1, 1, 1, 0, 5'd1, 5'd2, 5'd8, 0);
    tick();
    drive(1, 1, 0, 1, 5'd8, 5'd3, 5'd10, 0);
    chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_pcw", 32'(bus.pc_write), 32'd0);
    chk("lu_ifw", 32'(bus.if_id_write), 32'd0);
    tick();
    chk("lu_bubble_rs", 32'(bus.ID_Ex_Rs), 32'd0);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("lu_stall_clr", 32'(bus.stall), 32'd0);
    chk("lu_emrw", 32'(bus.Ex_Mem_RegWr), 32'd1);
    chk("lu_emrd", 32'(bus.Ex_Mem_Rd), 32'd8);
    tick();
    chk("lu_rs_after", 32'(bus.ID_Ex_Rs), 32'd8);
    chk("lu_mwrw", 32'(bus.Mem_Wr_RegWr), 32'd1);
    chk("lu_mwrd", 32'(bus.Mem_Wr_Rd), 32'd8);
    chk("lu_em_bubble", 32'(bus.Ex_Mem_RegWr), 32'd0);

    // Load into r0 never stalls
    drive(1, 1, 1, 0, 5'd2, 5'd3, 5'd0, 0);
    tick();
    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd11, 0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("r0_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("r0_emrw", 32'(bus.Ex_Mem_RegWr), 32'd1);
    chk("r0_emrd", 32'(bus.Ex_Mem_Rd), 32'd0);

    // Rt match only counts when Rt is a source
    drive(1, 1, 1, 0, 5'd1, 5'd1, 5'd9, 0);
    tick();
    drive(1, 1, 0, 0, 5'd4, 5'd9, 5'd12, 0);
    chk("rt_nouse_stall", 32'(bus.stall), 32'd0);
    drive(1, 1, 0, 1, 5'd4, 5'd9, 5'd12, 0);
    chk("rt_use_stall", 32'(bus.stall), 32'd1);
    tick();
    chk("rt_bubble_rt", 32'(bus.ID_Ex_Rt), 32'd0);
    chk("rt_cnt", 32'(bus.stall_cnt), 32'd2);
    tick();
    chk("rt_rt_after", 32'(bus.ID_Ex_Rt), 32'd9);

    // Flush overrides hazard
    drive(1, 1, 1, 0, 5'd1, 5'd1, 5'd12, 0);
    tick();
    drive(1, 1, 0, 0, 5'd12, 5'd3, 5'd13, 1);
    chk("fl_stall", 32'(bus.stall), 32'd0);
    chk("fl_pcw", 32'(bus.pc_write), 32'd1);
    tick();
    chk("fl_bubble_rs", 32'(bus.ID_Ex_Rs), 32'd0);
    chk("fl_cnt", 32'(bus.stall_cnt), 32'd2);

    // Non-load writer latency through the stages
    drive(1, 1, 0, 0, 5'd7, 5'd6, 5'd5, 0);
    tick();
    chk("lat_rs1", 32'(bus.ID_Ex_Rs), 32'd7);
    chk("lat_rt1", 32'(bus.ID_Ex_Rt), 32'd6);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd6, 0);
    tick();
    chk("lat_emrw2", 32'(bus.Ex_Mem_RegWr), 32'd1);
    chk("lat_emrd2", 32'(bus.Ex_Mem_Rd), 32'd5);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    chk("lat_mwrw3", 32'(bus.Mem_Wr_RegWr), 32'd1);
    chk("lat_mwrd3", 32'(bus.Mem_Wr_Rd), 32'd5);
    chk("inv_emrw", 32'(bus.Ex_Mem_RegWr), 32'd0);
    chk("inv_emrd", 32'(bus.Ex_Mem_Rd), 32'd6);
    tick();
    chk("inv_mwrw", 32'(bus.Mem_Wr_RegWr), 32'd0);
    chk("inv_mwrd", 32'(bus.Mem_Wr_Rd), 32'd6);

    // Mid-run reset clears counters
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst2");
    rst_n = 1'b1;

    // Five stalls: 2-bit counter saturates at 3
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd20, 0);
      tick();
      drive(1, 1, 0, 0, 5'd20, 5'd1, 5'd21, 0);
      chk("sat_stall", 32'(bus.stall), 32'd1);
      tick();
      chk("sat_cnt16", 32'(bus.stall_cnt), 32'(i));
      chk("sat_cnt2", 32'(bus2.stall_cnt), (i < 3) ? 32'(i) : 32'd3);
    end

    // Reset during a stall cycle
    drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd17, 0);
    tick();
    drive(1, 1, 0, 1, 5'd2, 5'd17, 5'd18, 0);
    chk("rs_stall_pre", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst3");
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst3_cnt_after", 32'(bus.stall_cnt), 32'd0);
    chk("rst3_stall_after", 32'(bus.stall), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
